npc_multicycle_ctrl: RTL and testbench

- Multi-cycle instruction sequencer for the NPC core; sits between the instruction-fetch unit, the load/store unit, the PC register and the register file.
- Classifies each fetched RV32I opcode itself and steps one instruction at a time through fetch, execute, optional memory access and writeback, pulsing the datapath write enables.
- Stops permanently on ebreak or on a fault (illegal opcode or memory timeout).

---
 rtl/npc_multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_npc_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/npc_multicycle_ctrl.sv
// npc_multicycle_ctrl: multi-cycle instruction sequencer for the NPC core.
// Steps one instruction at a time through fetch, execute, optional memory
// access and writeback, and times the PC / register-file write pulses.
// Stops permanently on ebreak (HALT) or on a fault (ERR) until reset.
module npc_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_inst,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_rvalid,
    output logic [31:0] inst_reg,
    output logic        pc_we,
    output logic        rf_we,
    output logic        halt,
    output logic        err,
    output logic [2:0]  state
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MREQ  = 3'd3,
        S_MWAIT = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t        state_q;
    logic [31:0]   inst_q;
    logic [CW-1:0] cnt_q;

    logic [6:0] opcode;
    logic       is_ebreak;
    logic       is_load;
    logic       is_store;
    logic       writes_rd;
    logic       is_legal;
    logic       cnt_at_max;

    // Classify the latched instruction and flag the last allowed wait cycle
    always_comb begin
        opcode     = inst_q[6:0];
        is_ebreak  = (inst_q == EBREAK);
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        writes_rd  = (opcode == OP_R)    || (opcode == OP_IALU)  ||
                     (opcode == OP_JALR) || (opcode == OP_LOAD)  ||
                     (opcode == OP_LUI)  || (opcode == OP_AUIPC) ||
                     (opcode == OP_JAL);
        is_legal   = writes_rd || is_store || (opcode == OP_BRANCH) || is_ebreak;
        cnt_at_max = (cnt_q == CW'(TIMEOUT - 1));
    end

    // Sequencer: state, latched instruction and shared wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    state_q <= S_IWAIT;
                    cnt_q   <= '0;
                end
                S_IWAIT: begin
                    if (ifu_rvalid) begin
                        inst_q  <= ifu_inst;
                        state_q <= S_EXEC;
                    end else if (cnt_at_max) begin
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EXEC: begin
                    if (is_ebreak)
                        state_q <= S_HALT;
                    else if (!is_legal)
                        state_q <= S_ERR;
                    else if (is_load || is_store)
                        state_q <= S_MREQ;
                    else
                        state_q <= S_WB;
                end
                S_MREQ: begin
                    state_q <= S_MWAIT;
                    cnt_q   <= '0;
                end
                S_MWAIT: begin
                    if (lsu_rvalid)
                        state_q <= S_WB;
                    else if (cnt_at_max)
                        state_q <= S_ERR;
                    else
                        cnt_q <= cnt_q + CW'(1);
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

    // Moore output decode; every output reads as zero while reset is held
    always_comb begin
        ifu_req  = 1'b0;
        lsu_req  = 1'b0;
        lsu_wen  = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        halt     = 1'b0;
        err      = 1'b0;
        inst_reg = '0;
        state    = '0;
        if (!rst) begin
            ifu_req  = (state_q == S_FETCH);
            lsu_req  = (state_q == S_MREQ);
            lsu_wen  = (state_q == S_MREQ) && is_store;
            pc_we    = (state_q == S_WB);
            rf_we    = (state_q == S_WB) && writes_rd && (inst_q[11:7] != 5'd0);
            halt     = (state_q == S_HALT);
            err      = (state_q == S_ERR);
            inst_reg = inst_q;
            state    = state_q;
        end
    end

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
// Directed testbench for npc_multicycle_ctrl: one instance at the default
// timeout, one at TIMEOUT=4 for the wait-limit boundary cases.
module tb_npc_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ifu_req, ifu_rvalid, lsu_req, lsu_wen, lsu_rvalid;
    logic        pc_we, rf_we, halt, err;
    logic [31:0] ifu_inst, inst_reg;
    logic [2:0]  state;

    logic        t_ifu_req, t_ifu_rvalid, t_lsu_req, t_lsu_wen, t_lsu_rvalid;
    logic        t_pc_we, t_rf_we, t_halt, t_err;
    logic [31:0] t_ifu_inst, t_inst_reg;
    logic [2:0]  t_state;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    npc_multicycle_ctrl #(.TIMEOUT(256)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ifu_inst(ifu_inst),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_rvalid(lsu_rvalid),
        .inst_reg(inst_reg), .pc_we(pc_we), .rf_we(rf_we),
        .halt(halt), .err(err), .state(state)
    );

    npc_multicycle_ctrl #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst),
        .ifu_req(t_ifu_req), .ifu_rvalid(t_ifu_rvalid), .ifu_inst(t_ifu_inst),
        .lsu_req(t_lsu_req), .lsu_wen(t_lsu_wen), .lsu_rvalid(t_lsu_rvalid),
        .inst_reg(t_inst_reg), .pc_we(t_pc_we), .rf_we(t_rf_we),
        .halt(t_halt), .err(t_err), .state(t_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for one edge; check forced-zero outputs, then the FETCH state
    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        check({tag, "_rst_outs"}, {25'd0, ifu_req, lsu_req, lsu_wen, pc_we, rf_we, halt, err}, 32'd0);
        check({tag, "_rst_state"}, {29'd0, state}, 32'd0);
        check({tag, "_rst_inst"}, inst_reg, 32'd0);
        rst = 1'b0;
        #1;
        check({tag, "_post_state"}, {29'd0, state}, 32'd0);
        check({tag, "_post_ifu_req"}, {31'd0, ifu_req}, 32'd1);
        check({tag, "_post_inst"}, inst_reg, 32'd0);
    endtask

    // Run one legal non-halting instruction on the main DUT, starting in FETCH
    task automatic run_inst(input string tag, input logic [31:0] inst,
                            input int unsigned iwait_extra, input int unsigned mwait_extra,
                            input bit is_mem, input bit is_store, input bit exp_rf);
        check({tag, "_fetch"}, {29'd0, state, 1'b0, ifu_req, pc_we, rf_we}, {29'd0, 3'd0, 4'b0100});
        tick();
        for (int i = 0; i < int'(iwait_extra); i++) begin
            check({tag, "_iwait"}, {29'd0, state}, 32'd1);
            tick();
        end
        ifu_rvalid = 1'b1;
        ifu_inst   = inst;
        check({tag, "_iwait_v"}, {28'd0, state, ifu_req}, {28'd0, 3'd1, 1'b0});
        tick();
        ifu_rvalid = 1'b0;
        ifu_inst   = 32'hDEAD_BEEF;
        check({tag, "_exec"}, {29'd0, state}, 32'd2);
        check({tag, "_inst_reg"}, inst_reg, inst);
        tick();
        if (is_mem) begin
            check({tag, "_mreq"}, {26'd0, state, lsu_req, lsu_wen, pc_we},
                  {26'd0, 3'd3, 1'b1, is_store, 1'b0});
            tick();
            for (int i = 0; i < int'(mwait_extra); i++) begin
                check({tag, "_mwait"}, {28'd0, state, lsu_req}, {28'd0, 3'd4, 1'b0});
                tick();
            end
            lsu_rvalid = 1'b1;
            check({tag, "_mwait_v"}, {29'd0, state}, 32'd4);
            tick();
            lsu_rvalid = 1'b0;
        end
        check({tag, "_wb"}, {26'd0, state, pc_we, rf_we, lsu_req}, {26'd0, 3'd5, 1'b1, exp_rf, 1'b0});
        tick();
        check({tag, "_next"}, {28'd0, state, pc_we}, {28'd0, 3'd0, 1'b0});
    endtask

    // Drive a terminating instruction and check the absorbing end state
    task automatic run_stop(input string tag, input logic [31:0] inst, input logic [2:0] exp_st);
        tick();
        ifu_rvalid = 1'b1;
        ifu_inst   = inst;
        tick();
        ifu_rvalid = 1'b0;
        check({tag, "_exec"}, {29'd0, state}, 32'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            check({tag, "_end"}, {27'd0, state, ifu_req, halt, err},
                  {27'd0, exp_st, 1'b0, exp_st == 3'd6, exp_st == 3'd7});
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifu_rvalid   = 1'b0;
        ifu_inst     = '0;
        lsu_rvalid   = 1'b0;
        t_ifu_rvalid = 1'b0;
        t_ifu_inst   = '0;
        t_lsu_rvalid = 1'b0;
        tick();
        do_reset("init");

        run_inst("addi",  32'h0050_0093, 0, 0, 1'b0, 1'b0, 1'b1);
        run_inst("lw",    32'h0000_A103, 0, 2, 1'b1, 1'b0, 1'b1);
        run_inst("sw",    32'h0020_A223, 0, 0, 1'b1, 1'b1, 1'b0);
        run_inst("beq",   32'h0000_0063, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("addix0",32'h0010_0013, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("jal",   32'h0080_00EF, 3, 0, 1'b0, 1'b0, 1'b1);
        // stray lsu_rvalid throughout a non-memory instruction must be ignored
        lsu_rvalid = 1'b1;
        run_inst("lui",   32'h1234_50B7, 1, 0, 1'b0, 1'b0, 1'b1);
        lsu_rvalid = 1'b0;

        // reset during MWAIT, then a late lsu_rvalid
        tick();
        ifu_rvalid = 1'b1;
        ifu_inst   = 32'h0000_A103;
        tick();
        ifu_rvalid = 1'b0;
        tick();
        tick();
        check("mw_state", {29'd0, state}, 32'd4);
        do_reset("mwrst");
        lsu_rvalid = 1'b1;
        tick();
        check("late_lsu", {28'd0, state, pc_we}, {28'd0, 3'd1, 1'b0});
        lsu_rvalid = 1'b0;
        do_reset("r2");

        run_stop("illegal", 32'h0000_007F, 3'd7);
        do_reset("r3");
        run_stop("ecall",   32'h0000_0073, 3'd7);
        do_reset("r4");
        run_stop("ebreak",  32'h0010_0073, 3'd6);
        do_reset("r5");

        // TIMEOUT=4: no fetch response -> ERR after four IWAIT cycles
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_iwait", {29'd0, t_state}, 32'd1);
            tick();
        end
        check("to_err", {28'd0, t_state, t_err}, {28'd0, 3'd7, 1'b1});
        tick();
        tick();
        check("to_err_held", {27'd0, t_state, t_err, t_ifu_req}, {27'd0, 3'd7, 1'b1, 1'b0});
        do_reset("r6");

        // TIMEOUT=4: response on the fourth IWAIT cycle is still accepted
        tick();
        for (int i = 0; i < 3; i++) tick();
        check("to4_iwait4", {29'd0, t_state}, 32'd1);
        t_ifu_rvalid = 1'b1;
        t_ifu_inst   = 32'h0000_A103;
        tick();
        t_ifu_rvalid = 1'b0;
        check("to4_exec", {28'd0, t_state, t_err}, {28'd0, 3'd2, 1'b0});
        check("to4_inst", t_inst_reg, 32'h0000_A103);
        tick();
        check("to4_mreq", {29'd0, t_state}, 32'd3);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to4_mwait", {29'd0, t_state}, 32'd4);
            tick();
        end
        check("to4_merr", {28'd0, t_state, t_err}, {28'd0, 3'd7, 1'b1});
        do_reset("r7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
